// File: rtl/seq_step_controller_pkg.sv
// Shared definitions for the step sequencer: FSM encoding, home code and the
// ring code-to-position map.
package seq_step_controller_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } fsm_state_e;

    localparam logic [2:0] HomeCode = 3'b100;

    // Ring codes in up-direction order, indexed by position.
    localparam logic [2:0] CodeP0 = 3'b100;
    localparam logic [2:0] CodeP1 = 3'b110;
    localparam logic [2:0] CodeP2 = 3'b011;
    localparam logic [2:0] CodeP3 = 3'b010;
    localparam logic [2:0] CodeP4 = 3'b111;
    localparam logic [2:0] CodeP5 = 3'b101;

    localparam logic [2:0] LastPos = 3'd5;

    function automatic logic [2:0] code_to_pos(input logic [2:0] code);
        logic [2:0] pos;
        case (code)
            CodeP0:  pos = 3'd0;
            CodeP1:  pos = 3'd1;
            CodeP2:  pos = 3'd2;
            CodeP3:  pos = 3'd3;
            CodeP4:  pos = 3'd4;
            CodeP5:  pos = 3'd5;
            default: pos = 3'd0;
        endcase
        return pos;
    endfunction

    function automatic logic is_off_ring(input logic [2:0] code);
        return code[2:1] == 2'b00;
    endfunction

endpackage

// File: rtl/seq_step_controller_next_state.sv
// 3-bit up/down ring next-state logic. Off-ring codes recover to 100 (up) or
// 101 (down), built from the high/low tie-offs.
module next_state
    import seq_step_controller_pkg::*;
(
    input  logic [2:0] current,
    input  logic       down,
    input  logic       high,
    input  logic       low,
    output logic [2:0] next
);

    always_comb begin
        next = {high, low, low};
        case (current)
            CodeP0:  next = down ? CodeP5 : CodeP1;
            CodeP1:  next = down ? CodeP0 : CodeP2;
            CodeP2:  next = down ? CodeP1 : CodeP3;
            CodeP3:  next = down ? CodeP2 : CodeP4;
            CodeP4:  next = down ? CodeP3 : CodeP5;
            CodeP5:  next = down ? CodeP4 : CodeP0;
            default: next = down ? {high, low, high} : {high, low, low};
        endcase
    end

endmodule

// File: rtl/seq_step_controller.sv
// Step sequencer: owns the ring state register and steps it a latched number
// of times in a latched direction, with hold/pause, load and wrap/illegal flags.
module seq_step_controller
    import seq_step_controller_pkg::*;
#(
    parameter int unsigned COUNT_W = 4,
    parameter logic [2:0]  HOME    = HomeCode
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               down,
    input  logic [COUNT_W-1:0] count,
    input  logic               hold,
    input  logic               load,
    input  logic [2:0]         load_value,
    output logic [2:0]         state,
    output logic [2:0]         position,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic               illegal
);

    fsm_state_e         fsm_q, fsm_d;
    logic [2:0]         state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               dir_q, dir_d;
    logic               wrap_q, wrap_d;
    logic               illegal_q, illegal_d;
    logic [2:0]         next_code;

    next_state u_next_state (
        .current (state_q),
        .down    (dir_q),
        .high    (1'b1),
        .low     (1'b0),
        .next    (next_code)
    );

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        wrap_d      = 1'b0;
        illegal_d   = illegal_q;

        case (fsm_q)
            StIdle: begin
                // Load takes priority over start when both arrive together.
                if (load) begin
                    state_d   = is_off_ring(load_value) ? HOME : load_value;
                    illegal_d = is_off_ring(load_value);
                end else if (start) begin
                    if (count != '0) begin
                        remaining_d = count;
                        dir_d       = down;
                        fsm_d       = StRun;
                    end else begin
                        fsm_d = StDone;
                    end
                end
            end
            StRun: begin
                if (hold) begin
                    fsm_d = StPause;
                end else if (remaining_q != '0) begin
                    state_d     = next_code;
                    remaining_d = remaining_q - 1'b1;
                    wrap_d      = dir_q ? (code_to_pos(state_q) == 3'd0)
                                        : (code_to_pos(state_q) == LastPos);
                    if (remaining_q == 1) begin
                        fsm_d = StDone;
                    end
                end else begin
                    fsm_d = StDone;
                end
            end
            StPause: begin
                if (!hold) begin
                    fsm_d = StRun;
                end
            end
            StDone: begin
                fsm_d = StIdle;
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= StIdle;
            state_q     <= HOME;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            wrap_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            wrap_q      <= wrap_d;
            illegal_q   <= illegal_d;
        end
    end

    assign state    = state_q;
    assign position = code_to_pos(state_q);
    assign busy     = (fsm_q == StRun) || (fsm_q == StPause);
    assign done     = (fsm_q == StDone);
    assign wrap     = wrap_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_seq_step_controller.sv
// Directed bench for seq_step_controller: a per-cycle vector table plus
// hand-written hold, mid-run reset and max-count sequences.
module tb_seq_step_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       down = 1'b0;
    logic [3:0] count = 4'd0;
    logic       hold = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_value = 3'd0;
    logic [2:0] state;
    logic [2:0] position;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    seq_step_controller #(
        .COUNT_W (4),
        .HOME    (3'b100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .down       (down),
        .count      (count),
        .hold       (hold),
        .load       (load),
        .load_value (load_value),
        .state      (state),
        .position   (position),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       dn;
        logic [3:0] cnt;
        logic       hd;
        logic       ld;
        logic [2:0] lv;
        logic [2:0] es;
        logic [2:0] ep;
        logic       eb;
        logic       ed;
        logic       ew;
        logic       ei;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic st, input logic dn,
                               input logic [3:0] cnt, input logic hd, input logic ld,
                               input logic [2:0] lv, input logic [2:0] es,
                               input logic [2:0] ep, input logic eb, input logic ed,
                               input logic ew, input logic ei);
        vec_t r;
        r = '{rst, st, dn, cnt, hd, ld, lv, es, ep, eb, ed, ew, ei};
        return r;
    endfunction

    // Apply inputs, then sample outputs 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic s, input logic d, input logic [3:0] c,
                         input logic h, input logic l, input logic [2:0] lv);
        reset = r; start = s; down = d; count = c; hold = h; load = l; load_value = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic chk(input string nm, input logic [2:0] es, input logic [2:0] ep,
                       input logic eb, input logic ed, input logic ew, input logic ei);
        logic [9:0] act;
        logic [9:0] exp;
        act = {state, position, busy, done, wrap, illegal};
        exp = {es, ep, eb, ed, ew, ei};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%b pos=%0d busy=%b done=%b wrap=%b ill=%b, want state=%b pos=%0d busy=%b done=%b wrap=%b ill=%b",
                     nm, state, position, busy, done, wrap, illegal, es, ep, eb, ed, ew, ei);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    vec_t vecs[22];
    logic [2:0] up_ring[6];

    initial begin
        up_ring = '{3'b100, 3'b110, 3'b011, 3'b010, 3'b111, 3'b101};

        //           rst st dn cnt hd ld lv      es      ep  eb ed ew ei
        vecs[0]  = v(1, 0, 0, 0,  0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 0);
        vecs[1]  = v(0, 1, 0, 3,  0, 0, 3'b000, 3'b100, 0, 1, 0, 0, 0);
        vecs[2]  = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b110, 1, 1, 0, 0, 0);
        vecs[3]  = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b011, 2, 1, 0, 0, 0);
        vecs[4]  = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b010, 3, 0, 1, 0, 0);
        vecs[5]  = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b010, 3, 0, 0, 0, 0);
        vecs[6]  = v(0, 0, 0, 0,  0, 1, 3'b100, 3'b100, 0, 0, 0, 0, 0);
        vecs[7]  = v(0, 1, 1, 6,  0, 0, 3'b000, 3'b100, 0, 1, 0, 0, 0);
        vecs[8]  = v(0, 0, 1, 0,  0, 0, 3'b000, 3'b101, 5, 1, 0, 1, 0);
        // start and a flipped down pin mid-run: both ignored
        vecs[9]  = v(0, 1, 0, 2,  0, 0, 3'b000, 3'b111, 4, 1, 0, 0, 0);
        vecs[10] = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b010, 3, 1, 0, 0, 0);
        vecs[11] = v(0, 0, 0, 0,  0, 1, 3'b111, 3'b011, 2, 1, 0, 0, 0);
        vecs[12] = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b110, 1, 1, 0, 0, 0);
        vecs[13] = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b100, 0, 0, 1, 0, 0);
        vecs[14] = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 0);
        vecs[15] = v(0, 0, 0, 0,  0, 1, 3'b001, 3'b100, 0, 0, 0, 0, 1);
        vecs[16] = v(0, 0, 0, 0,  0, 1, 3'b010, 3'b010, 3, 0, 0, 0, 0);
        vecs[17] = v(0, 0, 0, 0,  0, 1, 3'b000, 3'b100, 0, 0, 0, 0, 1);
        vecs[18] = v(0, 1, 0, 0,  0, 0, 3'b000, 3'b100, 0, 0, 1, 0, 1);
        vecs[19] = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 1);
        vecs[20] = v(0, 1, 0, 2,  0, 1, 3'b011, 3'b011, 2, 0, 0, 0, 0);
        vecs[21] = v(0, 0, 0, 0,  0, 0, 3'b000, 3'b011, 2, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].dn, vecs[i].cnt, vecs[i].hd,
                  vecs[i].ld, vecs[i].lv);
            chk($sformatf("vec%0d", i), vecs[i].es, vecs[i].ep, vecs[i].eb,
                vecs[i].ed, vecs[i].ew, vecs[i].ei);
        end

        // Hold after the 2nd step of an up run of 5 starting at 101.
        drive(0, 0, 0, 4'd0, 0, 1, 3'b101);
        chk("hold_load", 3'b101, 5, 0, 0, 0, 0);
        drive(0, 1, 0, 4'd5, 0, 0, 3'b000);
        chk("hold_start", 3'b101, 5, 1, 0, 0, 0);
        idle();
        chk("hold_step1", 3'b100, 0, 1, 0, 1, 0);
        idle();
        chk("hold_step2", 3'b110, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 4'd0, 1, 0, 3'b000);
            chk($sformatf("hold_frozen%0d", i), 3'b110, 1, 1, 0, 0, 0);
        end
        idle();
        chk("hold_resume", 3'b110, 1, 1, 0, 0, 0);
        idle();
        chk("hold_step3", 3'b011, 2, 1, 0, 0, 0);
        idle();
        chk("hold_step4", 3'b010, 3, 1, 0, 0, 0);
        idle();
        chk("hold_step5", 3'b111, 4, 0, 1, 0, 0);
        idle();
        chk("hold_idle", 3'b111, 4, 0, 0, 0, 0);

        // Reset asserted after step 7 of an up run of 15.
        drive(0, 0, 0, 4'd0, 0, 1, 3'b100);
        chk("rst_load", 3'b100, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 4'd15, 0, 0, 3'b000);
        chk("rst_start", 3'b100, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            idle();
            chk($sformatf("rst_step%0d", k), up_ring[k % 6], 3'(k % 6), 1, 0,
                (k % 6) == 0, 0);
        end
        drive(1, 0, 0, 4'd0, 0, 0, 3'b000);
        chk("rst_abort", 3'b100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("rst_after%0d", i), 3'b100, 0, 0, 0, 0, 0);
        end

        // Max count runs in full.
        begin
            int busy_cycles;
            int wraps;
            bit seen_done;
            busy_cycles = 0;
            wraps = 0;
            seen_done = 1'b0;
            drive(0, 1, 0, 4'd15, 0, 0, 3'b000);
            for (int i = 0; i < 40 && !seen_done; i++) begin
                if (busy) busy_cycles++;
                if (wrap) wraps++;
                if (done) seen_done = 1'b1;
                else idle();
            end
            chk_int("max_done_seen", int'(seen_done), 1);
            chk_int("max_busy_cycles", busy_cycles, 15);
            chk_int("max_wraps", wraps, 2);
            chk("max_final", 3'b010, 3, 0, 1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_step_controller.md
Name: seq_step_controller

Overview:
- Sequencer wrapped around the team's 3-bit up/down next-state logic (`next_state`). Owns the state register and steps it a programmed number of times in a latched direction.
- Handles start/hold/load control, tracks the ring position, and flags wrap and illegal codes.
- Sits between the control interface and the display/decoder logic that consumes `state`.

Parameters:
- COUNT_W, 4, width of step-count input and internal remaining-steps counter.
- HOME, 3'b100, reset/recovery state code (ring position 0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request run; sampled only in IDLE.
- down  input  1  direction (0 up, 1 down); latched on accepted start.
- count  input  COUNT_W  steps to execute; latched on accepted start.
- hold  input  1  pause stepping while high.
- load  input  1  load load_value into state; sampled only in IDLE.
- load_value  input  3  code to load.
- state  output  3  current sequence code.
- position  output  3  ring index 0..5 of state.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse at run completion.
- wrap  output  1  one-cycle pulse on a ring wrap step.
- illegal  output  1  sticky: last load requested 000 or 001.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=HOME, position=0, busy=0, done=0, wrap=0, illegal=0, FSM=IDLE, remaining=0, latched dir=0.
- Ring, up direction: 100(0) -> 110(1) -> 011(2) -> 010(3) -> 111(4) -> 101(5) -> 100(0).
- Ring, down direction: exact reverse.
- Codes 000 and 001 are off-ring: they step to 100 (up) or 101 (down). position reads 0 for these.
- Next code always comes from the `next_state` instance, with HIGH=1 and LOW=0 tied.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE + start, count != 0: latch count and down; go to RUN. busy rises the next cycle. The first step happens in the first RUN cycle.
- IDLE + start, count == 0: go to DONE with no step.
- IDLE + start and load in the same cycle: load wins, start is ignored.
- IDLE + load: state <= load_value, or HOME if load_value is 000/001. illegal <= (load_value is 000/001).
- RUN + hold=0: each cycle, state <= next, remaining <= remaining-1. When remaining==1, go to DONE after this step.
- RUN + hold=1: go to PAUSE with no step that cycle.
- PAUSE: state frozen; return to RUN the cycle after hold falls.
- DONE: done=1 for exactly this cycle, busy=0; go to IDLE next cycle.
- Exactly count steps are taken per run.
- wrap=1 in the cycle after a step from position 5 to 0 (up) or 0 to 5 (down). It is registered alongside state.
- start and load while busy are ignored, with no queuing. A change on the down pin mid-run has no effect.
- Max count (2^COUNT_W - 1) is executed in full; remaining never underflows.
- reset mid-run: abort immediately to reset values; no done pulse.
- position is combinational from state.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, PAUSE, DONE), HOME code, and the 3-bit code-to-position map constants.
- Sub-module: the existing `next_state` block, instantiated once with current=state and down=latched direction. No other sub-modules.

Test Plan:
- Reset then start up, count=3 -> state 100 -> 110 -> 011 -> 010 on consecutive cycles; done pulses once; busy low afterwards; position=3.
- From 100, start down, count=6 -> 101, 111, 010, 011, 110, 100. wrap pulses once, on the 100->101 step. Final state=100, position=0.
- Start up, count=5, hold high for 3 cycles after the 2nd step -> state frozen at 110 for 3 cycles; total 5 steps; final 111; done once.
- Load 001 in IDLE -> state=100, illegal=1. Then load 010 -> state=010, illegal=0. Load asserted while busy -> ignored.
- Start with count=0 -> no state change; done pulses on the next cycle. Start plus load in the same cycle -> only the load happens.
- Run up, count=15 from 100; assert reset at step 7 -> next cycle: state=100, busy=0, no done pulse, wrap=0.
